// File: rtl/load_store_unit.sv
// Memory-access stage between the address ALU and the register-file writeback.
// Runs one B/H/W access on a req/ready bus with steering, extension and faults.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] load_data,
    output logic        done,
    output logic        busy,
    output logic        misaligned,
    output logic        illegal,
    output logic        bus_error
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [2:0]    r_f3;
    logic [1:0]    r_off;
    logic          r_store;
    logic          r_ill;
    logic          r_mis;
    logic          r_berr;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_wstrb;
    logic [31:0]   r_load_data;
    logic [CW-1:0] r_cnt;

    logic          w_start;
    logic          w_illegal;
    logic          w_misal_raw;
    logic          w_misal;
    logic          w_fault;
    logic [31:0]   w_wdata;
    logic [3:0]    w_wstrb;
    logic [CW-1:0] w_cnt_inc;
    logic          w_timeout;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_ld;

    assign w_start   = start && (r_state == S_IDLE);
    assign w_misal   = !w_illegal && w_misal_raw;
    assign w_fault   = w_illegal || w_misal;
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && !mem_ready && (w_cnt_inc == LIM);

    // Size legality and natural-alignment checks on the incoming request
    always_comb begin
        w_illegal   = 1'b1;
        w_misal_raw = 1'b0;
        unique case (funct3)
            3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
            3'b100, 3'b101:         w_illegal = is_store;
            default:                w_illegal = 1'b1;
        endcase
        unique case (funct3[1:0])
            2'b01:   w_misal_raw = address[0];
            2'b10:   w_misal_raw = |address[1:0];
            default: w_misal_raw = 1'b0;
        endcase
    end

    // Store lane replication and byte strobes
    always_comb begin
        w_wdata = store_data;
        w_wstrb = 4'b1111;
        unique case (funct3[1:0])
            2'b00: begin
                w_wdata = {4{store_data[7:0]}};
                w_wstrb = 4'b0001 << address[1:0];
            end
            2'b01: begin
                w_wdata = {2{store_data[15:0]}};
                w_wstrb = 4'b0011 << address[1:0];
            end
            default: begin
                w_wdata = store_data;
                w_wstrb = 4'b1111;
            end
        endcase
    end

    // Load lane extraction and sign/zero extension
    always_comb begin
        w_byte = mem_rdata[{r_off, 3'b000} +: 8];
        w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (r_f3)
            3'b000:  w_ld = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ld = {{16{w_half[15]}}, w_half};
            3'b100:  w_ld = {24'd0, w_byte};
            3'b101:  w_ld = {16'd0, w_half};
            default: w_ld = mem_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_fault ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ready || w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // FSM-derived outputs; fault flags only visible alongside done
    always_comb begin
        mem_req    = (r_state == S_REQ);
        busy       = (r_state != S_IDLE);
        done       = (r_state == S_DONE);
        misaligned = done && r_mis;
        illegal    = done && r_ill;
        bus_error  = done && r_berr;
    end

    // Request latch, bus drive, timeout counting and load capture
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_f3        <= 3'd0;
            r_off       <= 2'd0;
            r_store     <= 1'b0;
            r_ill       <= 1'b0;
            r_mis       <= 1'b0;
            r_berr      <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_wstrb     <= 4'd0;
            r_load_data <= 32'd0;
            r_cnt       <= '0;
        end else if (w_start) begin
            r_f3    <= funct3;
            r_off   <= address[1:0];
            r_store <= is_store;
            r_ill   <= w_illegal;
            r_mis   <= w_misal;
            r_berr  <= 1'b0;
            r_cnt   <= '0;
            if (!w_fault) begin
                r_addr  <= {address[31:2], 2'b00};
                r_we    <= is_store;
                r_wdata <= w_wdata;
                r_wstrb <= is_store ? w_wstrb : 4'd0;
            end
        end else if (r_state == S_REQ) begin
            if (mem_ready) begin
                r_we    <= 1'b0;
                r_wstrb <= 4'd0;
                if (!r_store) begin
                    r_load_data <= w_ld;
                end
            end else begin
                r_cnt <= w_cnt_inc;
                if (w_timeout) begin
                    r_berr  <= 1'b1;
                    r_we    <= 1'b0;
                    r_wstrb <= 4'd0;
                end
            end
        end
    end

    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wstrb = r_wstrb;
    assign load_data = r_load_data;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed plan cases, reset abort, random accesses
// checked against an arithmetic reference model.
module tb_load_store_unit;

    localparam int T = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] address = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] load_data;
    logic        done;
    logic        busy;
    logic        misaligned;
    logic        illegal;
    logic        bus_error;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_ld = 32'd0;

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .is_store(is_store), .funct3(funct3), .address(address),
        .store_data(store_data), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .load_data(load_data), .done(done),
        .busy(busy), .misaligned(misaligned), .illegal(illegal),
        .bus_error(bus_error)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_illegal(input bit st, input int f3);
        if (f3 <= 2) return 1'b0;
        if (!st && (f3 == 4 || f3 == 5)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit ref_misal(input int f3, input logic [31:0] a);
        int sz;
        sz = 1 << (f3 % 4);
        return (a % sz) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input int f3, input int off, input logic [31:0] rd);
        logic [31:0] b;
        logic [31:0] h;
        b = (rd >> (8 * off)) & 32'hFF;
        h = (rd >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            0:       return (b >= 128) ? b - 32'd256 : b;
            1:       return (h >= 32768) ? h - 32'd65536 : h;
            4:       return b;
            5:       return h;
            default: return rd;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input int f3, input logic [31:0] d);
        if (f3 == 0) return (d & 32'hFF) * 32'h0101_0101;
        if (f3 == 1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [3:0] ref_strb(input int f3, input logic [31:0] a);
        int sz;
        int m;
        sz = 1 << f3;
        m = ((1 << sz) - 1) << (a % 4);
        return 4'(m);
    endfunction

    // One access from IDLE; dly = REQ cycles without ready before ready
    task automatic access(input bit st, input int f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] rd, input int dly);
        bit ill;
        bit mis;
        bit berr;
        int n;
        is_store = st;
        funct3 = 3'(f3);
        address = a;
        store_data = d;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        ill = ref_illegal(st, f3);
        mis = !ill && ref_misal(f3, a);
        berr = 1'b0;
        if (ill || mis) begin
            chk("flt_no_req", mem_req, 0);
        end else begin
            n = (dly + 1 <= T) ? dly + 1 : T;
            berr = (dly + 1 > T);
            for (int i = 1; i <= n; i++) begin
                chk("req", mem_req, 1);
                chk("addr", mem_addr, a & 32'hFFFF_FFFC);
                chk("we", mem_we, st);
                chk("wstrb", mem_wstrb, st ? ref_strb(f3, a) : 4'd0);
                if (st) chk("wdata", mem_wdata, ref_wdata(f3, d));
                chk("no_done", done, 0);
                mem_ready = (i == dly + 1);
                mem_rdata = rd;
                @(posedge clock); #1;
                mem_ready = 1'b0;
            end
            chk("req_drop", mem_req, 0);
            chk("we_drop", mem_we, 0);
            chk("wstrb_drop", mem_wstrb, 0);
            if (!berr && !st) exp_ld = ref_load(f3, int'(a % 4), rd);
        end
        chk("done", done, 1);
        chk("busy_done", busy, 1);
        chk("illegal", illegal, ill);
        chk("misaligned", misaligned, mis);
        chk("bus_error", bus_error, berr);
        chk("load_data", load_data, exp_ld);
        @(posedge clock); #1;
        chk("done_pulse", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_flags", {illegal, misaligned, bus_error}, 0);
    endtask

    initial begin
        #12;
        chk("rst_req", mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wstrb", mem_wstrb, 0);
        chk("rst_ld", load_data, 0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        access(0, 0, 32'h1003, 0, 32'h80AA_BBCC, 0);
        chk("lb_val", load_data, 32'hFFFF_FF80);
        access(0, 5, 32'h2002, 0, 32'h9234_5678, 0);
        chk("lhu_val", load_data, 32'h0000_9234);
        access(0, 1, 32'h2002, 0, 32'h9234_5678, 1);
        chk("lh_val", load_data, 32'hFFFF_9234);
        access(1, 0, 32'h3001, 32'h1234_56EF, 0, 0);
        access(1, 1, 32'h3002, 32'h1234_56EF, 0, 2);
        access(0, 2, 32'h4002, 0, 0, 0);
        access(0, 3, 32'h4000, 0, 0, 0);
        access(1, 4, 32'h4000, 0, 0, 0);
        access(0, 2, 32'h5000, 0, 32'hDEAD_BEEF, 10);
        access(0, 2, 32'h5004, 0, 32'hCAFE_F00D, 3);
        chk("ready_at_limit", load_data, 32'hCAFE_F00D);

        is_store = 1'b0;
        funct3 = 3'b010;
        address = 32'h7000;
        start = 1'b1;
        @(posedge clock); #1;
        address = 32'h7104;
        chk("ab_req", mem_req, 1);
        @(posedge clock); #1;
        start = 1'b0;
        chk("ignored_start", mem_addr, 32'h7000);
        chk("ab_req2", mem_req, 1);
        reset_n = 1'b0;
        #1;
        chk("ab_req_drop", mem_req, 0);
        chk("ab_busy_drop", busy, 0);
        exp_ld = 32'd0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            chk("ab_no_done", done, 0);
            chk("ab_idle", busy, 0);
        end
        chk("ab_ld", load_data, 0);

        for (int k = 0; k < 60; k++) begin
            access($urandom_range(0, 1), int'($urandom_range(0, 7)),
                   $urandom, $urandom, $urandom, int'($urandom_range(0, 5)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
